// File: rtl/ibuf_pkg.sv
// Shared definitions for the decoded-instruction buffer between fetch/decode and dispatch.
// The entry struct is declared MSB first so that opcode occupies the low bits.
package ibuf_pkg;

  localparam int unsigned ENTRY_W = 30;
  localparam int unsigned FETCH_W = 4;

  localparam int unsigned REG_W   = 4;
  localparam int unsigned OWNER_W = 4;

  localparam int unsigned OPCODE_LSB     = 0;
  localparam int unsigned RT_LSB         = 4;
  localparam int unsigned RA_LSB         = 8;
  localparam int unsigned RB_LSB         = 12;
  localparam int unsigned OPA_DEP_BIT    = 16;
  localparam int unsigned OPA_OWNER_LSB  = 17;
  localparam int unsigned OPB_DEP_BIT    = 21;
  localparam int unsigned OPB_OWNER_LSB  = 22;
  localparam int unsigned USES_RB_BIT    = 26;
  localparam int unsigned IS_LD_STR_BIT  = 27;
  localparam int unsigned IS_FXU_BIT     = 28;
  localparam int unsigned IS_BRANCH_BIT  = 29;

  typedef struct packed {
    logic               is_branch;
    logic               is_fxu;
    logic               is_ld_str;
    logic               uses_rb;
    logic [OWNER_W-1:0] op_b_owner;
    logic               op_b_local_dep;
    logic [OWNER_W-1:0] op_a_owner;
    logic               op_a_local_dep;
    logic [REG_W-1:0]   rb;
    logic [REG_W-1:0]   ra;
    logic [REG_W-1:0]   rt;
    logic [3:0]         opcode;
  } ibuf_entry_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(input ibuf_entry_t e);
    return e;
  endfunction

  function automatic ibuf_entry_t unpack_entry(input logic [ENTRY_W-1:0] v);
    return ibuf_entry_t'(v);
  endfunction

endpackage

// File: rtl/instruction_buffer.sv
// Four-lane in / four-lane out circular FIFO of decoded entries, flushed on a taken jump.
// Status outputs depend only on the registered count, never on the current inputs.
module instruction_buffer
  import ibuf_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [2:0]                 in_count,
  input  logic [FETCH_W*ENTRY_W-1:0] in_entry,
  output logic [2:0]                 num_free,
  output logic [FETCH_W-1:0]         out_valid,
  output logic [FETCH_W*ENTRY_W-1:0] out_entry,
  input  logic [2:0]                 deq_count,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]      head_q, head_d;
  logic [AW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic               err_q, err_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [CW-1:0] space;
  logic [2:0]    enq_n;
  logic [2:0]    deq_n;
  logic          ovf;
  logic          unf;

  always_comb begin
    space    = CW'(DEPTH) - count_q;
    num_free = (space >= CW'(FETCH_W)) ? 3'(FETCH_W) : space[2:0];

    ovf   = in_valid && (in_count > num_free);
    enq_n = in_valid ? (ovf ? num_free : in_count) : 3'd0;

    // count_q < deq_count <= 7 here, so the low three bits hold the whole value
    unf   = CW'(deq_count) > count_q;
    deq_n = unf ? count_q[2:0] : deq_count;

    head_d  = head_q + AW'(deq_n);
    tail_d  = tail_q + AW'(enq_n);
    count_d = count_q + CW'(enq_n) - CW'(deq_n);
    err_d   = err_q | ovf | unf;
  end

  always_comb begin
    out_valid = '0;
    out_entry = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      out_valid[i]                      = CW'(i) < count_q;
      out_entry[i*ENTRY_W +: ENTRY_W]   = mem_q[head_q + AW'(i)];
    end
  end

  assign occupancy = count_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset; lanes at or beyond count are never presented as valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (!rst && !flush && (3'(i) < enq_n)) begin
        mem_q[tail_q + AW'(i)] <= in_entry[i*ENTRY_W +: ENTRY_W];
      end
    end
  end

endmodule

// File: tb/tb_instruction_buffer.sv
// Randomised scoreboard bench: a queue-based model predicts the post-edge outputs, a monitor
// compares them one cycle at a time.
module tb_instruction_buffer;
  import ibuf_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = FETCH_W * ENTRY_W;

  logic                  clk = 1'b0;
  logic                  rst, flush, in_valid;
  logic [2:0]            in_count, deq_count;
  logic [LW-1:0]         in_entry;
  logic [2:0]            num_free;
  logic [FETCH_W-1:0]    out_valid;
  logic [LW-1:0]         out_entry;
  logic [$clog2(DEPTH):0] occupancy;
  logic                  err;

  instruction_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .in_entry  (in_entry),
    .num_free  (num_free),
    .out_valid (out_valid),
    .out_entry (out_entry),
    .deq_count (deq_count),
    .occupancy (occupancy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               occ;
    int               nfree;
    logic [3:0]       ovalid;
    logic [LW-1:0]    ent;
    logic             err;
  } exp_t;

  exp_t                exp_q[$];
  logic [ENTRY_W-1:0]  model_q[$];
  logic                model_err = 1'b0;
  int                  op_ctr = 0;
  int                  n_cmp = 0;
  int                  n_bad = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] rand_entry();
    ibuf_entry_t e;
    e        = unpack_entry(ENTRY_W'($urandom));
    e.opcode = op_ctr[3:0];
    op_ctr++;
    return pack_entry(e);
  endfunction

  // Drive one cycle of stimulus and push the outputs expected just after the next edge.
  task automatic cyc(input bit r, input bit f, input bit v, input int cnt, input int dq);
    exp_t e;
    int   free, enq, deqn, n;
    @(negedge clk);
    rst       = r;
    flush     = f;
    in_valid  = v;
    in_count  = cnt[2:0];
    deq_count = dq[2:0];
    for (int i = 0; i < FETCH_W; i++) in_entry[i*ENTRY_W +: ENTRY_W] = rand_entry();

    if (r) begin
      model_q.delete();
      model_err = 1'b0;
    end else if (f) begin
      model_q.delete();
    end else begin
      free = (DEPTH - model_q.size() < 4) ? DEPTH - model_q.size() : 4;
      enq  = v ? ((cnt < free) ? cnt : free) : 0;
      if (v && cnt > free) model_err = 1'b1;
      if (dq > model_q.size()) model_err = 1'b1;
      deqn = (dq < model_q.size()) ? dq : model_q.size();
      repeat (deqn) void'(model_q.pop_front());
      for (int i = 0; i < enq; i++) model_q.push_back(in_entry[i*ENTRY_W +: ENTRY_W]);
    end

    e.occ    = model_q.size();
    e.nfree  = (DEPTH - e.occ < 4) ? DEPTH - e.occ : 4;
    e.err    = model_err;
    e.ovalid = '0;
    e.ent    = '0;
    n = (e.occ < 4) ? e.occ : 4;
    for (int i = 0; i < n; i++) begin
      e.ovalid[i] = 1'b1;
      e.ent[i*ENTRY_W +: ENTRY_W] = model_q[i];
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("occupancy", LW'(occupancy), LW'(e.occ));
        chk("num_free", LW'(num_free), LW'(e.nfree));
        chk("out_valid", LW'(out_valid), LW'(e.ovalid));
        chk("err", LW'(err), LW'(e.err));
        for (int i = 0; i < FETCH_W; i++) begin
          if (e.ovalid[i]) begin
            chk($sformatf("lane%0d", i), LW'(out_entry[i*ENTRY_W +: ENTRY_W]),
                LW'(e.ent[i*ENTRY_W +: ENTRY_W]));
          end
        end
      end
    end
  end

  initial begin : stim
    bit fill_phase;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_count = '0; deq_count = '0; in_entry = '0;

    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    op_ctr = 0;
    cyc(0, 0, 1, 4, 0);            // opcodes 0..3
    cyc(0, 0, 0, 0, 2);            // lanes now 2,3
    repeat (3) cyc(0, 0, 1, 4, 0);
    cyc(0, 0, 1, 2, 0);            // full
    cyc(0, 0, 1, 3, 4);            // refused enqueue while popping, err set

    cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 4, 0);
    cyc(0, 0, 1, 2, 0);
    repeat (3) cyc(0, 0, 0, 0, 4);
    cyc(0, 0, 0, 0, 2);            // head at 14, buffer empty
    cyc(0, 0, 1, 4, 0);            // lands at 14,15,0,1
    cyc(0, 0, 0, 0, 4);

    cyc(0, 0, 1, 4, 0);
    cyc(0, 0, 1, 4, 0);
    cyc(0, 0, 1, 1, 0);            // occupancy 9
    cyc(0, 1, 1, 4, 2);            // flush wins, no err
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 3);            // underflow
    cyc(1, 1, 1, 4, 4);            // rst overrides flush

    fill_phase = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      bit r, f, v;
      int cnt, dq;
      if (c % 64 == 0) fill_phase = ~fill_phase;
      r   = ($urandom_range(0, 199) == 0);
      f   = ($urandom_range(0, 59) == 0);
      v   = ($urandom_range(0, 9) < 7);
      cnt = fill_phase ? $urandom_range(2, 4) : $urandom_range(0, 2);
      dq  = fill_phase ? $urandom_range(0, 2) : $urandom_range(2, 4);
      if ($urandom_range(0, 49) == 0) dq = $urandom_range(5, 7);
      cyc(r, f, v, cnt, dq);
    end

    cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", LW'(exp_q.size()), LW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
